// File: rtl/ghost_pos_update.sv
// Ghost position engine: samples a one-hot direction per tile, walks TILE pixels
// one move_tick at a time, detects capture by pacman and runs a timed respawn.
module ghost_pos_update #(
  parameter logic [10:0] START_X       = 11'd304,
  parameter logic [9:0]  START_Y       = 10'd224,
  parameter int          TILE          = 16,
  parameter logic [10:0] MAX_X         = 11'd639,
  parameter logic [9:0]  MAX_Y         = 10'd479,
  parameter int          HIT           = 8,
  parameter int          RESPAWN_TICKS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        move_tick,
  input  logic [3:0]  move_direction,
  input  logic [10:0] pacman_pos_x,
  input  logic [9:0]  pacman_pos_y,
  output logic [10:0] ghost_pos_x,
  output logic [9:0]  ghost_pos_y,
  output logic [3:0]  prev_direction,
  output logic        moving,
  output logic        caught
);

  localparam int SW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    MOVE    = 2'd2,
    RESPAWN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [10:0]     x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [3:0]      dir_q, dir_d;
  logic [3:0]      prev_q, prev_d;
  logic [SW-1:0]   step_q, step_d;
  logic [RW-1:0]   resp_q, resp_d;
  logic            caught_q, caught_d;

  logic [11:0]     dx, dy, adx;
  logic [10:0]     ady;
  logic            near;
  logic            hit;
  logic            dir_onehot;

  // One extra bit on each difference keeps the magnitude free of wrap-around.
  always_comb begin
    dx  = {1'b0, pacman_pos_x} - {1'b0, x_q};
    dy  = {2'b00, pacman_pos_y} - {2'b00, y_q};
    adx = dx[11] ? (12'd0 - dx) : dx;
    ady = dy[10] ? (11'd0 - dy[10:0]) : dy[10:0];
    near = (adx < 12'(HIT)) && (ady < 11'(HIT));
    hit  = enable && near && ((state_q == SAMPLE) || (state_q == MOVE));
    dir_onehot = (move_direction != 4'b0000) &&
                 ((move_direction & (move_direction - 4'd1)) == 4'b0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= START_X;
      y_q      <= START_Y;
      dir_q    <= '0;
      prev_q   <= '0;
      step_q   <= '0;
      resp_q   <= '0;
      caught_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      resp_q   <= resp_d;
      caught_q <= caught_d;
    end
  end

  // Capture is checked ahead of the tick so a coincident tick never steps.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    prev_d   = prev_q;
    step_d   = step_q;
    resp_d   = resp_q;
    caught_d = 1'b0;

    if (state_q == IDLE) begin
      if (enable) state_d = SAMPLE;
    end else if (hit) begin
      state_d  = RESPAWN;
      resp_d   = RW'(RESPAWN_TICKS - 1);
      caught_d = 1'b1;
    end else if (enable && move_tick) begin
      case (state_q)
        SAMPLE: begin
          if (dir_onehot) begin
            dir_d   = move_direction;
            step_d  = SW'(TILE - 1);
            state_d = MOVE;
          end
        end
        MOVE: begin
          case (dir_q)
            DIR_RIGHT: if (x_q < MAX_X)  x_d = x_q + 11'd1;
            DIR_LEFT:  if (x_q != '0)    x_d = x_q - 11'd1;
            DIR_UP:    if (y_q != '0)    y_d = y_q - 10'd1;
            DIR_DOWN:  if (y_q < MAX_Y)  y_d = y_q + 10'd1;
            default: ;
          endcase
          if (step_q == '0) begin
            prev_d  = dir_q;
            state_d = SAMPLE;
          end else begin
            step_d = step_q - SW'(1);
          end
        end
        RESPAWN: begin
          if (resp_q == '0) begin
            x_d     = START_X;
            y_d     = START_Y;
            prev_d  = '0;
            state_d = SAMPLE;
          end else begin
            resp_d = resp_q - RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ghost_pos_x    = x_q;
    ghost_pos_y    = y_q;
    prev_direction = prev_q;
    moving         = (state_q == MOVE);
    caught         = caught_q;
  end

endmodule

// File: tb/tb_ghost_pos_update.sv
// Cycle-level scoreboard bench for ghost_pos_update: a reference model predicts
// every registered output per clock, plus targeted constant checks per scenario.
module tb_ghost_pos_update;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        move_tick = 1'b0;
  logic [3:0]  move_direction = 4'b0000;
  logic [10:0] pacman_pos_x = 11'd639;
  logic [9:0]  pacman_pos_y = 10'd479;
  logic [10:0] ghost_pos_x;
  logic [9:0]  ghost_pos_y;
  logic [3:0]  prev_direction;
  logic        moving;
  logic        caught;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  prev;
    logic        mv;
    logic        ct;
  } exp_t;

  exp_t sbq[$];

  // Reference model state: 0=IDLE 1=SAMPLE 2=MOVE 3=RESPAWN
  int         m_state;
  int         m_x, m_y, m_cnt, m_resp;
  logic [3:0] m_dir, m_prev;
  logic       m_caught;

  ghost_pos_update #(
    .START_X(11'd304), .START_Y(10'd224), .TILE(16), .MAX_X(11'd639),
    .MAX_Y(10'd479), .HIT(8), .RESPAWN_TICKS(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .move_tick(move_tick),
    .move_direction(move_direction), .pacman_pos_x(pacman_pos_x),
    .pacman_pos_y(pacman_pos_y), .ghost_pos_x(ghost_pos_x),
    .ghost_pos_y(ghost_pos_y), .prev_direction(prev_direction),
    .moving(moving), .caught(caught)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0; m_x = 304; m_y = 224; m_cnt = 0; m_resp = 0;
    m_dir = 4'b0000; m_prev = 4'b0000; m_caught = 1'b0;
  endfunction

  function automatic void model_step(input logic tick);
    int adx, ady;
    logic cap;
    adx = int'(pacman_pos_x) - m_x; if (adx < 0) adx = -adx;
    ady = int'(pacman_pos_y) - m_y; if (ady < 0) ady = -ady;
    cap = (m_state == 1 || m_state == 2) && enable && adx < 8 && ady < 8;
    m_caught = 1'b0;
    if (m_state == 0) begin
      if (enable) m_state = 1;
    end else if (cap) begin
      m_state = 3; m_resp = 63; m_caught = 1'b1;
    end else if (enable && tick) begin
      if (m_state == 1) begin
        if ($countones(move_direction) == 1) begin
          m_dir = move_direction; m_cnt = 15; m_state = 2;
        end
      end else if (m_state == 2) begin
        if (m_dir == 4'b0001 && m_x < 639) m_x++;
        if (m_dir == 4'b1000 && m_x > 0)   m_x--;
        if (m_dir == 4'b0010 && m_y > 0)   m_y--;
        if (m_dir == 4'b0100 && m_y < 479) m_y++;
        if (m_cnt == 0) begin m_prev = m_dir; m_state = 1; end
        else m_cnt--;
      end else begin
        if (m_resp == 0) begin
          m_x = 304; m_y = 224; m_prev = 4'b0000; m_state = 1;
        end else m_resp--;
      end
    end
  endfunction

  // Drives one clock with the given tick; called and returns at a negedge.
  task automatic cycle(input logic tick);
    exp_t e;
    move_tick = tick;
    model_step(tick);
    e.x = 11'(m_x); e.y = 10'(m_y); e.prev = m_prev;
    e.mv = (m_state == 2); e.ct = m_caught;
    sbq.push_back(e);
    @(negedge clk);
    move_tick = 1'b0;
    e = sbq.pop_front();
    checks += 5;
    if (ghost_pos_x !== e.x) begin failures++; $display("FAIL sb_pos_x t=%0t got=%0d exp=%0d", $time, ghost_pos_x, e.x); end
    if (ghost_pos_y !== e.y) begin failures++; $display("FAIL sb_pos_y t=%0t got=%0d exp=%0d", $time, ghost_pos_y, e.y); end
    if (prev_direction !== e.prev) begin failures++; $display("FAIL sb_prev t=%0t got=%b exp=%b", $time, prev_direction, e.prev); end
    if (moving !== e.mv) begin failures++; $display("FAIL sb_moving t=%0t got=%b exp=%b", $time, moving, e.mv); end
    if (caught !== e.ct) begin failures++; $display("FAIL sb_caught t=%0t got=%b exp=%b", $time, caught, e.ct); end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin cycle(1'b1); cycle(1'b0); end
  endtask

  task automatic run_tile(input logic [3:0] d);
    move_direction = d;
    cycle(1'b1);
    ticks(16);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks += 4;
    if (ghost_pos_x !== 11'd304 || ghost_pos_y !== 10'd224) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(304,224)", ghost_pos_x, ghost_pos_y); end
    if (prev_direction !== 4'b0000) begin failures++; $display("FAIL reset_prev got=%b exp=0000", prev_direction); end
    if (moving !== 1'b0) begin failures++; $display("FAIL reset_moving got=%b exp=0", moving); end
    if (caught !== 1'b0) begin failures++; $display("FAIL reset_caught got=%b exp=0", caught); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // IDLE with enable low ignores a valid tick
    move_direction = 4'b0001;
    cycle(1'b1);
    cycle(1'b0);
  endtask

  task automatic test_first_tile();
    enable = 1'b1;
    cycle(1'b0);
    move_direction = 4'b0001;
    cycle(1'b1);
    checks++;
    if (moving !== 1'b1) begin failures++; $display("FAIL first_tile_moving got=%b exp=1", moving); end
    ticks(16);
    checks += 3;
    if (ghost_pos_x !== 11'd320) begin failures++; $display("FAIL first_tile_x got=%0d exp=320", ghost_pos_x); end
    if (prev_direction !== 4'b0001) begin failures++; $display("FAIL first_tile_prev got=%b exp=0001", prev_direction); end
    if (moving !== 1'b0) begin failures++; $display("FAIL first_tile_done got=%b exp=0", moving); end
  endtask

  task automatic test_dir_change();
    move_direction = 4'b0001;
    cycle(1'b1);
    ticks(5);
    move_direction = 4'b0010;
    ticks(11);
    checks += 3;
    if (ghost_pos_x !== 11'd336 || ghost_pos_y !== 10'd224) begin failures++; $display("FAIL dir_hold_pos got=(%0d,%0d) exp=(336,224)", ghost_pos_x, ghost_pos_y); end
    if (prev_direction !== 4'b0001) begin failures++; $display("FAIL dir_hold_prev got=%b exp=0001", prev_direction); end
    cycle(1'b1);
    if (moving !== 1'b1) begin failures++; $display("FAIL up_tile_start got=%b exp=1", moving); end
    ticks(16);
    checks++;
    if (ghost_pos_y !== 10'd208 || prev_direction !== 4'b0010) begin failures++; $display("FAIL up_tile got=(y=%0d,prev=%b) exp=(208,0010)", ghost_pos_y, prev_direction); end
  endtask

  task automatic test_illegal_dir();
    move_direction = 4'b0110;
    repeat (3) cycle(1'b1);
    checks++;
    if (moving !== 1'b0 || ghost_pos_x !== 11'd336 || ghost_pos_y !== 10'd208) begin failures++; $display("FAIL multi_hot got=(mv=%b,%0d,%0d) exp=(0,336,208)", moving, ghost_pos_x, ghost_pos_y); end
    move_direction = 4'b0000;
    repeat (3) cycle(1'b1);
    checks++;
    if (moving !== 1'b0 || ghost_pos_x !== 11'd336) begin failures++; $display("FAIL zero_dir got=(mv=%b,%0d) exp=(0,336)", moving, ghost_pos_x); end
  endtask

  task automatic test_freeze();
    move_direction = 4'b1000;
    cycle(1'b1);
    ticks(4);
    enable = 1'b0;
    repeat (10) cycle(1'b1);
    checks++;
    if (ghost_pos_x !== 11'd332 || moving !== 1'b1) begin failures++; $display("FAIL freeze got=(%0d,mv=%b) exp=(332,1)", ghost_pos_x, moving); end
    enable = 1'b1;
    ticks(12);
    checks++;
    if (ghost_pos_x !== 11'd320 || prev_direction !== 4'b1000 || moving !== 1'b0) begin failures++; $display("FAIL resume got=(%0d,%b,mv=%b) exp=(320,1000,0)", ghost_pos_x, prev_direction, moving); end
  endtask

  task automatic test_left_bound();
    repeat (19) run_tile(4'b1000);
    move_direction = 4'b1000;
    cycle(1'b1);
    ticks(15);
    checks++;
    if (ghost_pos_x !== 11'd1) begin failures++; $display("FAIL near_edge got=%0d exp=1", ghost_pos_x); end
    ticks(1);
    checks++;
    if (ghost_pos_x !== 11'd0 || moving !== 1'b0) begin failures++; $display("FAIL at_edge got=(%0d,mv=%b) exp=(0,0)", ghost_pos_x, moving); end
    cycle(1'b1);
    ticks(15);
    checks++;
    if (ghost_pos_x !== 11'd0 || moving !== 1'b1) begin failures++; $display("FAIL blocked_15 got=(%0d,mv=%b) exp=(0,1)", ghost_pos_x, moving); end
    ticks(1);
    checks++;
    if (ghost_pos_x !== 11'd0 || moving !== 1'b0) begin failures++; $display("FAIL blocked_16 got=(%0d,mv=%b) exp=(0,0)", ghost_pos_x, moving); end
  endtask

  task automatic test_capture();
    move_direction = 4'b0001;
    cycle(1'b1);
    ticks(3);
    pacman_pos_x = 11'd11; pacman_pos_y = 10'd208;
    repeat (2) cycle(1'b0);
    checks++;
    if (caught !== 1'b0) begin failures++; $display("FAIL hit_edge got=%b exp=0", caught); end
    pacman_pos_x = 11'd10; pacman_pos_y = 10'd201;
    cycle(1'b1);
    checks++;
    if (caught !== 1'b1 || ghost_pos_x !== 11'd3 || moving !== 1'b0) begin failures++; $display("FAIL capture got=(ct=%b,%0d,mv=%b) exp=(1,3,0)", caught, ghost_pos_x, moving); end
    pacman_pos_x = 11'd639; pacman_pos_y = 10'd479;
    cycle(1'b0);
    checks++;
    if (caught !== 1'b0) begin failures++; $display("FAIL caught_pulse got=%b exp=0", caught); end
    ticks(63);
    checks++;
    if (ghost_pos_x !== 11'd3 || ghost_pos_y !== 10'd208) begin failures++; $display("FAIL respawn_wait got=(%0d,%0d) exp=(3,208)", ghost_pos_x, ghost_pos_y); end
    ticks(1);
    checks++;
    if (ghost_pos_x !== 11'd304 || ghost_pos_y !== 10'd224 || prev_direction !== 4'b0000) begin failures++; $display("FAIL respawn got=(%0d,%0d,%b) exp=(304,224,0000)", ghost_pos_x, ghost_pos_y, prev_direction); end
  endtask

  task automatic test_reset_mid();
    move_direction = 4'b0001;
    cycle(1'b1);
    ticks(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ghost_pos_x !== 11'd304 || ghost_pos_y !== 10'd224 || prev_direction !== 4'b0000 || moving !== 1'b0 || caught !== 1'b0) begin
      failures++; $display("FAIL async_reset got=(%0d,%0d,%b,mv=%b,ct=%b) exp=(304,224,0000,0,0)", ghost_pos_x, ghost_pos_y, prev_direction, moving, caught);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0);
    checks++;
    if (ghost_pos_x !== 11'd304 || moving !== 1'b0) begin failures++; $display("FAIL post_reset got=(%0d,mv=%b) exp=(304,0)", ghost_pos_x, moving); end
    run_tile(4'b0100);
    checks++;
    if (ghost_pos_y !== 10'd240 || prev_direction !== 4'b0100) begin failures++; $display("FAIL down_tile got=(%0d,%b) exp=(240,0100)", ghost_pos_y, prev_direction); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_tile();
    test_dir_change();
    test_illegal_dir();
    test_freeze();
    test_left_bound();
    test_capture();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ghost_pos_update.md
GHOST_POS_UPDATE -- requirements
Module: ghost_pos_update

Interface
REQ-001 SHALL provide these parameters:
- START_X, 11'd304, respawn/reset x position.
- START_Y, 10'd224, respawn/reset y position.
- TILE, 16, pixels per committed move; valid range 2..64.
- MAX_X, 11'd639, largest legal x.
- MAX_Y, 10'd479, largest legal y.
- HIT, 8, capture window in pixels per axis.
- RESPAWN_TICKS, 64, move_ticks spent in RESPAWN.

REQ-002 SHALL provide these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  game running; low freezes all motion.
- move_tick  in  1  one-clk pulse; one pixel step per pulse.
- move_direction  in  4  one-hot from ghost_control; RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000.
- pacman_pos_x  in  11  pacman x.
- pacman_pos_y  in  10  pacman y.
- ghost_pos_x  out  11  ghost x, registered.
- ghost_pos_y  out  10  ghost y, registered.
- prev_direction  out  4  last completed tile direction; feeds ghost_control.
- moving  out  1  high while state is MOVE.
- caught  out  1  one-clk pulse on capture.

Function
REQ-003 SHALL implement FSM states IDLE, SAMPLE, MOVE, RESPAWN.
REQ-004 IDLE -> SAMPLE when enable=1; no other IDLE exit.
REQ-005 SAMPLE, move_tick=1, move_direction exactly one-hot:
- latch move_direction into dir_q;
- step_cnt <= TILE-1;
- go to MOVE.
REQ-006 SAMPLE, move_tick=1, move_direction zero or multi-hot: stay in SAMPLE; position unchanged.
REQ-007 MOVE, each move_tick: step one pixel per dir_q.
- RIGHT: x+1; LEFT: x-1; UP: y-1; DOWN: y+1.
- Position register updates on the same clk edge that samples move_tick (latency 1 clk).
REQ-008 MOVE, move_tick with step_cnt==0:
- perform the final step;
- prev_direction <= dir_q;
- go to SAMPLE.
- Otherwise decrement step_cnt.
REQ-009 dir_q SHALL stay constant for the whole tile; move_direction changes during MOVE are ignored.
REQ-010 Saturate at bounds:
- x never below 0 nor above MAX_X; y never below 0 nor above MAX_Y.
- A blocked step leaves the coordinate unchanged but still counts toward step_cnt.
REQ-011 Capture condition, evaluated every clk in SAMPLE or MOVE on current registered positions: |pacman_pos_x-ghost_pos_x| < HIT and |pacman_pos_y-ghost_pos_y| < HIT.
- Compute differences with one extra bit so there is no wrap.
REQ-012 On capture:
- caught=1 for exactly one clk (registered, next edge);
- go to RESPAWN; resp_cnt <= RESPAWN_TICKS-1;
- position frozen.
REQ-013 Capture and move_tick in the same cycle: capture wins; no step is taken.
REQ-014 RESPAWN: decrement resp_cnt on each move_tick. At move_tick with resp_cnt==0:
- ghost_pos <= (START_X, START_Y);
- prev_direction <= 0000;
- go to SAMPLE.
- No capture detection while in RESPAWN.
REQ-015 enable=0 in SAMPLE, MOVE or RESPAWN: ignore move_tick; hold state, counters and position.
- Resume exactly where frozen when enable returns high.
- Only reset returns the FSM to IDLE.
REQ-016 moving=1 iff state==MOVE; caught=0 in every cycle other than REQ-012.

Reset
REQ-017 While rst_n=0, immediately and independent of clk:
- state=IDLE;
- ghost_pos_x=START_X, ghost_pos_y=START_Y;
- prev_direction=0000;
- moving=0, caught=0;
- dir_q=0000, step_cnt=0, resp_cnt=0.
REQ-018 Reset asserted mid-tile or mid-respawn SHALL abandon the operation with no residual step on release.
REQ-019 First FSM transition SHALL occur no earlier than the first clk edge after rst_n deasserts.

Verification
REQ-020 Reset release, enable=1, move_direction=0001, pacman far away, 16 ticks -> x goes 304..320, prev_direction=0001 after the 16th tick, moving falls.
REQ-021 In MOVE with dir RIGHT, switch move_direction to 0010 after tick 5 -> all 16 steps still RIGHT; the UP tile starts on the next SAMPLE tick.
REQ-022 Ghost at x=1, dir LEFT, 16 ticks -> x reaches 0 and holds 0; FSM returns to SAMPLE after exactly 16 ticks.
REQ-023 Pacman placed at (ghost_x+7, ghost_y-7) -> caught pulses 1 clk. Then 64 ticks -> position (304,224), prev_direction=0000. A tick coincident with capture produces no step.
REQ-024 move_direction=0110 or 0000 in SAMPLE -> no motion, stays in SAMPLE. enable low for 10 ticks mid-tile -> position frozen; tile completes 16 total steps after resume.
REQ-025 rst_n pulsed low mid-tile, between clk edges -> outputs return to reset values before the next edge; state is IDLE.
